// File: rtl/knn_query_sequencer.sv
// Host-side sequencer for the KNN classifier core: reset pulse, settle window, capture, result stream.
// Optional build macro KNN_VOTE_CHECK_EN adds the vote_err majority/final consistency flag.
module knn_query_sequencer #(
   parameter int unsigned RST_CYCLES    = 3,
   parameter int unsigned SETTLE_CYCLES = 160,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q_valid,
   output logic             q_ready,
   input  logic [63:0]      q_data,
   input  logic             abort,
   output logic             knn_rst_n,
   output logic [63:0]      test_vector,
   input  logic [3:0]       knn_c1,
   input  logic [3:0]       knn_c2,
   input  logic [3:0]       knn_c3,
   input  logic [3:0]       knn_c4,
   input  logic [3:0]       knn_c5,
   input  logic [3:0]       knn_final,
   output logic             r_valid,
   input  logic             r_ready,
   output logic [3:0]       r_class,
   output logic [19:0]      r_nbr,
   output logic             busy,
   output logic [CNT_W-1:0] query_count
`ifdef KNN_VOTE_CHECK_EN
   ,
   output logic             vote_err
`endif
);

   localparam int unsigned CLS_W   = 4;
   localparam int unsigned NBR_N   = 5;
   localparam int unsigned NBR_W   = NBR_N * CLS_W;
   localparam int unsigned TMR_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_RESULT} state_t;

   state_t             state, state_nxt;
   logic [TMR_W-1:0]   tmr;
   logic [NBR_W-1:0]   nbr_in;
   logic               accept, capture, xfer;
   logic               q_ready_d, knn_rst_n_d, busy_d, r_valid_d;

   assign nbr_in  = {knn_c5, knn_c4, knn_c3, knn_c2, knn_c1};
   assign accept  = (state == S_IDLE) && q_valid && q_ready;
   assign capture = (state == S_RUN) && (tmr == '0) && !abort;
   assign xfer    = r_valid && r_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; abort wins over RUN completion
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (q_valid && q_ready) state_nxt = S_RESET;
         S_RESET:  if (abort) state_nxt = S_IDLE;
                   else if (tmr == '0) state_nxt = S_RUN;
         S_RUN:    if (abort) state_nxt = S_IDLE;
                   else if (tmr == '0) state_nxt = S_RESULT;
         S_RESULT: if (r_valid && r_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state so every output leaves a flop
   always_comb begin
      q_ready_d   = 1'b0;
      knn_rst_n_d = 1'b0;
      busy_d      = 1'b0;
      r_valid_d   = 1'b0;
      case (state_nxt)
         S_IDLE:   q_ready_d = 1'b1;
         S_RESET:  busy_d = 1'b1;
         S_RUN:    begin busy_d = 1'b1; knn_rst_n_d = 1'b1; end
         S_RESULT: begin knn_rst_n_d = 1'b1; r_valid_d = 1'b1; end
         default:  q_ready_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_ready   <= 1'b0;
         knn_rst_n <= 1'b0;
         busy      <= 1'b0;
         r_valid   <= 1'b0;
      end else begin
         q_ready   <= q_ready_d;
         knn_rst_n <= knn_rst_n_d;
         busy      <= busy_d;
         r_valid   <= r_valid_d;
      end
   end

   // Phase timer: reset-pulse length, then settle window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr <= '0;
      end else begin
         case (state)
            S_IDLE:  if (accept) tmr <= TMR_W'(RST_CYCLES - 1);
            S_RESET: tmr <= (tmr == '0) ? TMR_W'(SETTLE_CYCLES - 1) : tmr - TMR_W'(1);
            S_RUN:   if (tmr != '0) tmr <= tmr - TMR_W'(1);
            default: tmr <= tmr;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         test_vector <= '0;
         r_class     <= '0;
         r_nbr       <= '0;
         query_count <= '0;
      end else begin
         if (accept)  test_vector <= q_data;
         if (capture) begin
            r_class <= knn_final;
            r_nbr   <= nbr_in;
         end
         if (xfer)    query_count <= query_count + CNT_W'(1);
      end
   end

`ifdef KNN_VOTE_CHECK_EN
   logic [2:0] hits;
   logic       vote_err_c;

   // Flag a neighbour majority (>=3 of 5) that disagrees with the core's final class
   always_comb begin
      vote_err_c = 1'b0;
      hits       = '0;
      for (int i = 0; i < int'(NBR_N); i++) begin
         hits = '0;
         for (int j = 0; j < int'(NBR_N); j++)
            hits = hits + 3'(nbr_in[i*CLS_W +: CLS_W] == nbr_in[j*CLS_W +: CLS_W]);
         if ((hits >= 3'd3) && (nbr_in[i*CLS_W +: CLS_W] != knn_final)) vote_err_c = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          vote_err <= 1'b0;
      else if (capture) vote_err <= vote_err_c;
      else if (xfer)    vote_err <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Scoreboard bench for knn_query_sequencer with a settle-aware KNN core model.
// Define KNN_VOTE_CHECK_EN for both files to exercise vote_err.
module tb_knn_query_sequencer;

   localparam int unsigned RST_CYCLES    = 3;
   localparam int unsigned SETTLE_CYCLES = 160;
   localparam int unsigned CNT_W         = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             q_valid;
   logic             q_ready;
   logic [63:0]      q_data;
   logic             abort;
   logic             knn_rst_n;
   logic [63:0]      test_vector;
   logic [3:0]       knn_c1, knn_c2, knn_c3, knn_c4, knn_c5, knn_final;
   logic             r_valid;
   logic             r_ready;
   logic [3:0]       r_class;
   logic [19:0]      r_nbr;
   logic             busy;
   logic [CNT_W-1:0] query_count;
`ifdef KNN_VOTE_CHECK_EN
   logic             vote_err;
`endif

   knn_query_sequencer #(
      .RST_CYCLES(RST_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
      .abort(abort), .knn_rst_n(knn_rst_n), .test_vector(test_vector),
      .knn_c1(knn_c1), .knn_c2(knn_c2), .knn_c3(knn_c3), .knn_c4(knn_c4), .knn_c5(knn_c5),
      .knn_final(knn_final), .r_valid(r_valid), .r_ready(r_ready), .r_class(r_class),
      .r_nbr(r_nbr), .busy(busy), .query_count(query_count)
`ifdef KNN_VOTE_CHECK_EN
      , .vote_err(vote_err)
`endif
   );

   always #5 clk = ~clk;

   // Core model: correct answer only once the core has been out of reset for the settle window
   logic [3:0]  model_final = '0;
   logic [19:0] model_nbr   = '0;
   int unsigned run_cyc     = 0;
   logic        settled;
   always @(posedge clk) run_cyc <= knn_rst_n ? run_cyc + 1 : 0;
   assign settled   = knn_rst_n && (run_cyc >= SETTLE_CYCLES - 1);
   assign knn_final = settled ? model_final : ~model_final;
   assign {knn_c5, knn_c4, knn_c3, knn_c2, knn_c1} = settled ? model_nbr : ~model_nbr;

   typedef struct {
      logic [3:0]  cls;
      logic [19:0] nbr;
      logic        verr;
   } exp_t;

   exp_t             sb_q[$];
   int               tests = 0;
   int               fails = 0;
   logic [CNT_W-1:0] exp_count = '0;
   bit               just_xfer = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference vote rule: some class occurs 3+ times among the neighbours and is not the final class
   function automatic logic vote_ref(input logic [3:0] fin, input logic [19:0] nbr);
      int cnt[16];
      logic [3:0] c;
      for (int v = 0; v < 16; v++) cnt[v] = 0;
      for (int i = 0; i < 5; i++) begin
         c = nbr[4*i +: 4];
         cnt[c]++;
      end
      for (int v = 0; v < 16; v++)
         if (cnt[v] >= 3 && 4'(v) != fin) return 1'b1;
      return 1'b0;
   endfunction

   // Monitor: every accepted result is popped from the scoreboard and compared
   always @(negedge clk) begin
      exp_t e;
      if (!rst && r_valid && r_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_result", 64'(1), 64'(0));
         end else begin
            e = sb_q.pop_front();
            chk("r_class", 64'(r_class), 64'(e.cls));
            chk("r_nbr", 64'(r_nbr), 64'(e.nbr));
`ifdef KNN_VOTE_CHECK_EN
            chk("vote_err", 64'(vote_err), 64'(e.verr));
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a query and return just after its accept edge
   task automatic wait_accept(input logic [63:0] vec, output bit ok);
      q_data  = vec;
      q_valid = 1'b1;
      ok      = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (just_xfer) begin
            chk("q_ready_after_xfer", 64'(q_ready), 64'(1));
            chk("r_valid_after_xfer", 64'(r_valid), 64'(0));
            chk("query_count", 64'(query_count), 64'(exp_count));
            just_xfer = 0;
         end
         if (q_ready) begin
            ok = 1;
            break;
         end
         step();
      end
      if (!ok) chk("accept_timeout", 64'(0), 64'(1));
      else step();
   endtask

   task automatic do_query(input logic [63:0] vec, input logic [3:0] fin, input logic [19:0] nbr,
                           input int abort_run, input int stall, input bit hold_valid);
      bit ok;
      int n_rv;
      logic [3:0]  cap_cls;
      logic [19:0] cap_nbr;
      model_final = fin;
      model_nbr   = nbr;
      wait_accept(vec, ok);
      if (!ok) return;
      if (abort_run < 0) sb_q.push_back('{fin, nbr, vote_ref(fin, nbr)});
      if (!hold_valid) q_valid = 1'b0;
      r_ready = (stall == 0);
      // Cycle k = k-th cycle after the accept edge: RESET for k<=RST_CYCLES, then RUN
      for (int k = 1; k <= int'(RST_CYCLES + SETTLE_CYCLES); k++) begin
         if (k > 1) step();
         abort = (abort_run >= 0) && (k == int'(RST_CYCLES) + abort_run);
         if (hold_valid) q_data = {$urandom, $urandom};
         @(negedge clk);
         chk("test_vector_held", test_vector, vec);
         chk("knn_rst_n_phase", 64'(knn_rst_n), 64'(k > int'(RST_CYCLES)));
         chk("busy", 64'(busy), 64'(1));
         chk("q_ready_busy", 64'(q_ready), 64'(0));
         chk("r_valid_early", 64'(r_valid), 64'(0));
         if (abort) begin
            step();
            abort = 1'b0;
            @(negedge clk);
            chk("abort_knn_rst_n", 64'(knn_rst_n), 64'(0));
            chk("abort_busy", 64'(busy), 64'(0));
            chk("abort_q_ready", 64'(q_ready), 64'(1));
            n_rv = 0;
            repeat (SETTLE_CYCLES + 10) begin
               @(negedge clk);
               if (r_valid) n_rv++;
            end
            chk("abort_no_result", 64'(n_rv), 64'(0));
            chk("abort_query_count", 64'(query_count), 64'(exp_count));
            step();
            return;
         end
      end
      step();
      if (hold_valid) q_data = {$urandom, $urandom};
      @(negedge clk);
      chk("result_latency", 64'(r_valid), 64'(1));
      for (int i = 0; i < 10 && !r_valid; i++) @(negedge clk);
      if (!r_valid) begin
         chk("result_timeout", 64'(0), 64'(1));
         return;
      end
      chk("result_knn_rst_n", 64'(knn_rst_n), 64'(1));
      chk("result_busy", 64'(busy), 64'(0));
      chk("result_q_ready", 64'(q_ready), 64'(0));
      cap_cls = r_class;
      cap_nbr = r_nbr;
      for (int s = 1; s < stall; s++) begin
         step();
         if (hold_valid) q_data = {$urandom, $urandom};
         @(negedge clk);
         chk("stall_r_valid", 64'(r_valid), 64'(1));
         chk("stall_r_class", 64'(r_class), 64'(cap_cls));
         chk("stall_r_nbr", 64'(r_nbr), 64'(cap_nbr));
         chk("stall_test_vector", test_vector, vec);
         chk("stall_knn_rst_n", 64'(knn_rst_n), 64'(1));
         chk("stall_q_ready", 64'(q_ready), 64'(0));
      end
      if (stall > 0) begin
         step();
         r_ready = 1'b1;
         @(negedge clk);
         chk("pre_xfer_r_valid", 64'(r_valid), 64'(1));
      end
      step();
      exp_count = exp_count + CNT_W'(1);
      just_xfer = 1;
   endtask

   initial begin
      bit ok;
      logic [19:0] rn;
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      logic [19:0] rn;
      rst = 1'b1; q_valid = 1'b0; q_data = '0; abort = 1'b0; r_ready = 1'b0;
      @(negedge clk);
      chk("rst_q_ready", 64'(q_ready), 64'(0));
      chk("rst_knn_rst_n", 64'(knn_rst_n), 64'(0));
      chk("rst_test_vector", test_vector, 64'(0));
      chk("rst_r_valid", 64'(r_valid), 64'(0));
      chk("rst_r_class", 64'(r_class), 64'(0));
      chk("rst_r_nbr", 64'(r_nbr), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_query_count", 64'(query_count), 64'(0));
`ifdef KNN_VOTE_CHECK_EN
      chk("rst_vote_err", 64'(vote_err), 64'(0));
`endif
      step();
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      chk("idle_q_ready", 64'(q_ready), 64'(1));
      step();

      do_query(64'h0034_0024_000F_0003, 4'd0, 20'h00000, -1, 0, 0);
      do_query(64'h0045_0021_002E_000F, 4'd1, 20'h11121, -1, 20, 0);
      do_query(64'h0040_0022_003B_0018, 4'd3, 20'h33333, 50, 0, 0);
      do_query(64'h0012_0034_0056_0078, 4'd5, 20'h55455, -1, 2, 0);
      do_query(64'hDEAD_BEEF_0000_1111, 4'd7, 20'h77777, int'(SETTLE_CYCLES), 0, 0);
      do_query(64'hA5A5_5A5A_0F0F_F0F0, 4'd6, 20'h12345, -1, 0, 1);
      do_query(64'h0102_0304_0506_0708, 4'd2, 20'h11120, -1, 1, 0);
      do_query(64'h1111_2222_3333_4444, 4'd2, 20'h22110, -1, 0, 0);

      // rst mid-RUN: everything returns to reset values, partial result discarded
      model_final = 4'd9;
      model_nbr   = 20'h99999;
      wait_accept(64'hCAFE_F00D_1234_5678, ok);
      q_valid = 1'b0;
      repeat (RST_CYCLES + 40) step();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_q_ready", 64'(q_ready), 64'(0));
      chk("midrst_knn_rst_n", 64'(knn_rst_n), 64'(0));
      chk("midrst_test_vector", test_vector, 64'(0));
      chk("midrst_r_valid", 64'(r_valid), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_query_count", 64'(query_count), 64'(0));
      step();
      rst = 1'b0;
      exp_count = '0;
      just_xfer = 0;
      step();
      @(negedge clk);
      chk("midrst_release_q_ready", 64'(q_ready), 64'(1));
      step();

      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < 5; i++) rn[4*i +: 4] = 4'($urandom_range(0, 3));
         do_query({$urandom, $urandom}, 4'($urandom_range(0, 3)), rn, -1,
                  int'($urandom_range(0, 4)), 0);
      end

      @(negedge clk);
      if (just_xfer) begin
         chk("final_q_ready", 64'(q_ready), 64'(1));
         chk("final_query_count", 64'(query_count), 64'(exp_count));
      end
      chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
